// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with lock and bounded bursts sharing one BRAM port
// between the convolution engine and the PS-side loader.
module bram_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wrdata0,
    input  logic [DATA_W-1:0] wrdata1,
    input  logic [3:0]        we0,
    input  logic [3:0]        we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rddata,
    output logic [ADDR_W-1:0] BRAM_addr,
    output logic [DATA_W-1:0] BRAM_wrdata,
    output logic [3:0]        BRAM_we,
    input  logic [DATA_W-1:0] BRAM_rddata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } owner_t;

    localparam logic [7:0] CNT_MAX = 8'(MAX_BEATS - 1);

    owner_t     owner;
    logic       last;
    logic [7:0] cnt;
    logic       beat0;
    logic       beat1;
    logic       rel0;
    logic       rel1;
    logic       at_max;

    assign gnt0   = (owner == OWN0);
    assign gnt1   = (owner == OWN1);
    assign busy   = gnt0 | gnt1;
    assign rddata = BRAM_rddata;

    assign beat0  = req0 & gnt0;
    assign beat1  = req1 & gnt1;
    assign at_max = (cnt == CNT_MAX);

    // Forced release only applies while the other side is waiting.
    assign rel0 = ~req0 | (beat0 & (~lock0 | (at_max & req1)));
    assign rel1 = ~req1 | (beat1 & (~lock1 | (at_max & req0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            owner   <= IDLE;
            last    <= 1'b1;
            cnt     <= 8'd0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= beat0 & (we0 == 4'd0);
            rvalid1 <= beat1 & (we1 == 4'd0);
            unique case (owner)
                IDLE: begin
                    cnt <= 8'd0;
                    if (req0 & (~req1 | last))
                        owner <= OWN0;
                    else if (req1)
                        owner <= OWN1;
                end
                OWN0: begin
                    if (rel0) begin
                        last  <= 1'b0;
                        cnt   <= 8'd0;
                        owner <= req1 ? OWN1 : IDLE;
                    end else if (beat0 && !at_max) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                OWN1: begin
                    if (rel1) begin
                        last  <= 1'b1;
                        cnt   <= 8'd0;
                        owner <= req0 ? OWN0 : IDLE;
                    end else if (beat1 && !at_max) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    owner <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        BRAM_addr   = '0;
        BRAM_wrdata = '0;
        BRAM_we     = 4'd0;
        if (gnt0) begin
            BRAM_addr   = addr0;
            BRAM_wrdata = wrdata0;
            BRAM_we     = we0 & {4{req0}};
        end else if (gnt1) begin
            BRAM_addr   = addr1;
            BRAM_wrdata = wrdata1;
            BRAM_we     = we1 & {4{req1}};
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboarded bench for bram_port_arbiter with a behavioural BRAM
// and scripted arbitration scenarios.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, lock0, lock1;
    logic [31:0] addr0, addr1, wrdata0, wrdata1;
    logic [3:0]  we0, we1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [31:0] rddata, BRAM_addr, BRAM_wrdata, BRAM_rddata;
    logic [3:0]  BRAM_we;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        bit          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rv0_cnt = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .DATA_W(32),
        .ADDR_W(32),
        .MAX_BEATS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .req1(req1),
        .lock0(lock0),
        .lock1(lock1),
        .addr0(addr0),
        .addr1(addr1),
        .wrdata0(wrdata0),
        .wrdata1(wrdata1),
        .we0(we0),
        .we1(we1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .rvalid0(rvalid0),
        .rvalid1(rvalid1),
        .rddata(rddata),
        .BRAM_addr(BRAM_addr),
        .BRAM_wrdata(BRAM_wrdata),
        .BRAM_we(BRAM_we),
        .BRAM_rddata(BRAM_rddata),
        .busy(busy)
    );

    // Read-first BRAM with one cycle read latency.
    always @(posedge clk) begin
        BRAM_rddata <= mem[BRAM_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (BRAM_we[b])
                mem[BRAM_addr[9:2]][b*8 +: 8] <= BRAM_wrdata[b*8 +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rvalid0)
            rv0_cnt++;
        if (rvalid0 && rvalid1)
            check("rv_both", 32'd1, 32'd0);
        if (rvalid0 || rvalid1) begin
            if (sb.size() == 0) begin
                check("sb_unexp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_id", {31'd0, rvalid1}, {31'd0, e.id});
                check("sb_data", rddata, e.data);
            end
        end
        if (!reset) begin
            if (req0 && gnt0) begin
                if (we0 == 4'd0)
                    sb.push_back('{1'b0, ref_mem[addr0[9:2]]});
                else
                    ref_mem[addr0[9:2]] = wrdata0;
            end
            if (req1 && gnt1) begin
                if (we1 == 4'd0)
                    sb.push_back('{1'b1, ref_mem[addr1[9:2]]});
                else
                    ref_mem[addr1[9:2]] = wrdata1;
            end
        end
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000 + i;
            ref_mem[i] = 32'h1000 + i;
        end
        mem[4]     = 32'hA5;
        ref_mem[4] = 32'hA5;
        reset = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wrdata0 = 0; wrdata1 = 0;
        we0 = 0; we1 = 0;
        step();
        step();
        @(negedge clk);
        check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {28'd0, BRAM_we}, 32'd0);
        check("rst_addr", BRAM_addr, 32'd0);
        check("rst_wd", BRAM_wrdata, 32'd0);
        step();
        reset = 1'b0;

        // single read
        req0 = 1; addr0 = 32'h10;
        step();
        @(negedge clk);
        check("a_gnt0", {31'd0, gnt0}, 32'd1);
        check("a_addr", BRAM_addr, 32'h10);
        step();
        req0 = 0;
        @(negedge clk);
        check("a_rv0", {31'd0, rvalid0}, 32'd1);
        check("a_rd", rddata, 32'hA5);
        check("a_busy", {31'd0, busy}, 32'd0);
        step();

        // simultaneous requests from reset
        reset = 1;
        step();
        reset = 0;
        req0 = 1; req1 = 1; addr0 = 32'h20; addr1 = 32'h24;
        step();
        @(negedge clk);
        check("b_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        req0 = 0;
        @(negedge clk);
        check("b_hand", {30'd0, gnt1, gnt0}, 32'd2);
        step();
        req1 = 0;
        @(negedge clk);
        check("b_idle", {31'd0, busy}, 32'd0);
        step();
        req0 = 1; req1 = 1;
        step();
        @(negedge clk);
        check("b_tie2", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        req0 = 0; req1 = 0;
        step();
        step();

        // locked read-modify-write burst
        base = rv0_cnt;
        req0 = 1; lock0 = 1; addr0 = 32'h30; we0 = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                we0 = 4'hF; wrdata0 = 32'h1234; lock0 = 0;
            end
            @(negedge clk);
            check("c_gnt0", {31'd0, gnt0}, 32'd1);
            check("c_we", {28'd0, BRAM_we}, (i == 3) ? 32'hF : 32'h0);
            step();
        end
        req0 = 0; we0 = 0;
        step();
        step();
        @(negedge clk);
        check("c_rvcnt", rv0_cnt - base, 32'd3);
        step();
        req0 = 1; addr0 = 32'h30;
        step();
        step();
        req0 = 0;
        @(negedge clk);
        check("c_wb", rddata, 32'h1234);
        step();

        // forced release after MAX_BEATS beats
        req0 = 1; lock0 = 1; addr0 = 32'h40;
        step();
        req1 = 1; lock1 = 0; addr1 = 32'h44; we1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("d_hold", {30'd0, gnt1, gnt0}, 32'd1);
            step();
        end
        @(negedge clk);
        check("d_force", {30'd0, gnt1, gnt0}, 32'd2);
        step();
        req1 = 0; lock0 = 0;
        @(negedge clk);
        check("d_regain", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        req0 = 0;
        step();
        step();

        // reset in the middle of a burst
        req0 = 1; lock0 = 1; addr0 = 32'h50;
        step();
        @(negedge clk);
        check("e_gnt0", {31'd0, gnt0}, 32'd1);
        step();
        reset = 1;
        step();
        reset = 0; req0 = 0; lock0 = 0;
        @(negedge clk);
        check("e_rv0", {31'd0, rvalid0}, 32'd0);
        check("e_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("e_we", {28'd0, BRAM_we}, 32'd0);
        step();
        req0 = 1; req1 = 1; addr0 = 32'h54; addr1 = 32'h58;
        step();
        @(negedge clk);
        check("e_tie", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        req0 = 0; req1 = 0;
        step();
        step();

        // pending writer must not leak onto the port
        req0 = 1; lock0 = 1; addr0 = 32'h60;
        step();
        req1 = 1; lock1 = 0; addr1 = 32'h70; we1 = 4'hF;
        wrdata1 = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            addr0 = 32'h60 + 32'(4 * i);
            if (i == 2)
                lock0 = 0;
            @(negedge clk);
            check("f_we", {28'd0, BRAM_we}, 32'd0);
            check("f_addr", BRAM_addr, 32'h60 + 32'(4 * i));
            check("f_gnt1", {31'd0, gnt1}, 32'd0);
            step();
        end
        req0 = 0;
        @(negedge clk);
        check("f_own1", {30'd0, gnt1, gnt0}, 32'd2);
        check("f_we1", {28'd0, BRAM_we}, 32'hF);
        step();
        req1 = 0; we1 = 0;
        step();
        req1 = 1; addr1 = 32'h70;
        step();
        step();
        req1 = 0;
        @(negedge clk);
        check("f_rv1", {31'd0, rvalid1}, 32'd1);
        check("f_rb", rddata, 32'hDEADBEEF);
        step();
        step();

        check("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
